// File: rtl/alert_pkg.sv
// Shared types and constants for the alert trigger and its cooldown timer.
package alert_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONFIRM  = 3'd1,
    FIRE     = 3'd2,
    COOLDOWN = 3'd3,
    REARM    = 3'd4
  } state_t;

  // Width of the hit/miss frame counters (parameters are limited to 1..15).
  localparam int CNT_W = 4;

  // Default timing: 2 s of cooldown at a 50 MHz system clock.
  localparam int CLK_HZ           = 50_000_000;
  localparam int COOLDOWN_DEFAULT = 2 * CLK_HZ;

endpackage

// File: rtl/cooldown_timer.sv
// One-shot cycle timer: load starts a run of COOLDOWN_CYCLES cycles, done
// pulses in the last cycle of the run. Also intended for the buzzer duration.
module cooldown_timer
  import alert_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = COOLDOWN_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(COOLDOWN_CYCLES - 1);

  logic [CW-1:0] count;

  // The run ends when the counter has spent COOLDOWN_CYCLES cycles busy.
  assign done = busy && (count == LAST);

  // Counter and busy flag; clear aborts a run and wins over load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      count <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alert_trigger.sv
// Turns per-frame detection results into a single-cycle buzzer trigger with
// N-frame confirmation, a post-fire cooldown and a miss-based re-arm.
module alert_trigger
  import alert_pkg::*;
#(
  parameter int CONFIRM_FRAMES  = 3,
  parameter int RELEASE_FRAMES  = 2,
  parameter int COOLDOWN_CYCLES = COOLDOWN_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             det_valid,
  input  logic             det_hit,
  output logic             trigger,
  output logic             armed,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] CONFIRM_N = CNT_W'(CONFIRM_FRAMES);
  localparam logic [CNT_W-1:0] RELEASE_N = CNT_W'(RELEASE_FRAMES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] hit_nx;
  logic [CNT_W-1:0] miss_cnt, miss_nx;
  logic             cool_load, cool_clear, cool_busy, cool_done;
  logic             frame_hit, frame_miss;

  assign frame_hit  = det_valid &  det_hit;
  assign frame_miss = det_valid & ~det_hit;
  assign armed      = (state == IDLE) || (state == CONFIRM);

  cooldown_timer #(
    .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
  ) u_cooldown (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cool_clear),
    .load   (cool_load),
    .busy   (cool_busy),
    .done   (cool_done)
  );

  // Next-state and counter logic; enable low overrides every transition.
  always_comb begin
    state_nx   = state;
    hit_nx     = hit_count;
    miss_nx    = miss_cnt;
    cool_load  = 1'b0;
    cool_clear = 1'b0;
    if (!enable) begin
      state_nx   = IDLE;
      hit_nx     = '0;
      miss_nx    = '0;
      cool_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          hit_nx = '0;
          if (frame_hit) begin
            hit_nx   = ONE;
            state_nx = (CONFIRM_N == ONE) ? FIRE : CONFIRM;
          end
        end
        CONFIRM: begin
          if (frame_hit) begin
            if (hit_count + ONE >= CONFIRM_N) begin
              hit_nx   = CONFIRM_N;
              state_nx = FIRE;
            end else begin
              hit_nx = hit_count + ONE;
            end
          end else if (frame_miss) begin
            hit_nx   = '0;
            state_nx = IDLE;
          end
        end
        FIRE: begin
          cool_load = 1'b1;
          state_nx  = COOLDOWN;
        end
        COOLDOWN: begin
          // An idle timer here would mean a lost run; fall through to re-arm
          // rather than lock up.
          if (cool_done || !cool_busy) begin
            miss_nx  = '0;
            state_nx = REARM;
          end
        end
        REARM: begin
          if (frame_miss) begin
            if (miss_cnt + ONE >= RELEASE_N) begin
              miss_nx  = '0;
              hit_nx   = '0;
              state_nx = IDLE;
            end else begin
              miss_nx = miss_cnt + ONE;
            end
          end else if (frame_hit) begin
            miss_nx = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          hit_nx   = '0;
          miss_nx  = '0;
        end
      endcase
    end
  end

  // State, counters and the registered trigger, high exactly while in FIRE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hit_count <= '0;
      miss_cnt  <= '0;
      trigger   <= 1'b0;
    end else begin
      state     <= state_nx;
      hit_count <= hit_nx;
      miss_cnt  <= miss_nx;
      trigger   <= (state_nx == FIRE);
    end
  end

endmodule

// File: tb/tb_alert_trigger.sv
// Directed bench for alert_trigger: vector tables for the two parameter sets
// plus hand-written asynchronous reset sequences.
module tb_alert_trigger;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en0 = 1'b1, v0 = 1'b0, h0 = 1'b0;
  logic       en1 = 1'b1, v1 = 1'b0, h1 = 1'b0;
  logic       trig0, armed0, trig1, armed1;
  logic [3:0] hc0, hc1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit       dut;
    bit       en;
    bit       v;
    bit       h;
    bit       trig;
    bit       armed;
    bit [3:0] hc;
    int       grp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alert_trigger #(
    .CONFIRM_FRAMES (3),
    .RELEASE_FRAMES (2),
    .COOLDOWN_CYCLES(20)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (en0),
    .det_valid(v0),
    .det_hit  (h0),
    .trigger  (trig0),
    .armed    (armed0),
    .hit_count(hc0)
  );

  alert_trigger #(
    .CONFIRM_FRAMES (1),
    .RELEASE_FRAMES (2),
    .COOLDOWN_CYCLES(20)
  ) u_dut_c1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (en1),
    .det_valid(v1),
    .det_hit  (h1),
    .trigger  (trig1),
    .armed    (armed1),
    .hit_count(hc1)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input bit d, input bit en, input bit v, input bit h,
                     input bit t, input bit a, input int hc, input int g);
    vec_t x;
    x.dut = d; x.en = en; x.v = v; x.h = h;
    x.trig = t; x.armed = a; x.hc = 4'(hc); x.grp = g;
    vecs.push_back(x);
  endtask

  task automatic hit(input bit d, input bit t, input bit a, input int hc, input int g);
    add(d, 1'b1, 1'b1, 1'b1, t, a, hc, g);
  endtask

  task automatic miss(input bit d, input bit t, input bit a, input int hc, input int g);
    add(d, 1'b1, 1'b1, 1'b0, t, a, hc, g);
  endtask

  task automatic idl(input int n, input bit d, input bit t, input bit a, input int hc, input int g);
    for (int k = 0; k < n; k++) add(d, 1'b1, 1'b0, 1'b0, t, a, hc, g);
  endtask

  task automatic dis(input bit d, input bit v, input bit h, input bit t, input bit a,
                     input int hc, input int g);
    add(d, 1'b0, v, h, t, a, hc, g);
  endtask

  task automatic step0(input bit en, input bit v, input bit h);
    en0 = en; v0 = v; h0 = h;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Group 2: three hits with 5-cycle gaps fire one cycle after the third.
    hit(0, 0, 1, 1, 2); idl(5, 0, 0, 1, 1, 2);
    hit(0, 0, 1, 2, 2); idl(5, 0, 0, 1, 2, 2);
    hit(0, 1, 0, 3, 2); idl(1, 0, 0, 0, 3, 2);
    // Group 4: hits every 4 cycles through cooldown and REARM never retrigger.
    for (int k = 0; k < 8; k++) begin
      hit(0, 0, 0, 3, 4); idl(3, 0, 0, 0, 3, 4);
    end
    miss(0, 0, 0, 3, 4); idl(3, 0, 0, 0, 3, 4);
    miss(0, 0, 1, 0, 4);
    hit(0, 0, 1, 1, 4); idl(3, 0, 0, 1, 1, 4);
    hit(0, 0, 1, 2, 4); idl(3, 0, 0, 1, 2, 4);
    hit(0, 1, 0, 3, 4);
    // Group 7: exact cooldown length; last cooldown cycle ignores a miss,
    // a hit in REARM restarts the miss count.
    idl(20, 0, 0, 0, 3, 7);
    miss(0, 0, 0, 3, 7);
    miss(0, 0, 0, 3, 7);
    hit(0, 0, 0, 3, 7);
    miss(0, 0, 0, 3, 7);
    miss(0, 0, 1, 0, 7);
    // Group 3: hit, hit, miss, hit, hit never fires.
    hit(0, 0, 1, 1, 3); hit(0, 0, 1, 2, 3); miss(0, 0, 1, 0, 3);
    hit(0, 0, 1, 1, 3); hit(0, 0, 1, 2, 3); miss(0, 0, 1, 0, 3);
    // Group 5: enable low mid-cooldown aborts it; next 3 hits fire at once.
    hit(0, 0, 1, 1, 5); hit(0, 0, 1, 2, 5); hit(0, 1, 0, 3, 5);
    idl(10, 0, 0, 0, 3, 5);
    dis(0, 0, 0, 0, 1, 0, 5);
    hit(0, 0, 1, 1, 5); hit(0, 0, 1, 2, 5); hit(0, 1, 0, 3, 5);
    idl(1, 0, 0, 0, 3, 5);
    dis(0, 0, 0, 0, 1, 0, 5);
    // Group 8: enable low blocks a confirming hit and an in-flight FIRE.
    hit(0, 0, 1, 1, 8); hit(0, 0, 1, 2, 8);
    dis(0, 1, 1, 0, 1, 0, 8);
    hit(0, 0, 1, 1, 8); hit(0, 0, 1, 2, 8); hit(0, 1, 0, 3, 8);
    dis(0, 0, 0, 0, 1, 0, 8);
    hit(0, 0, 1, 1, 8); hit(0, 0, 1, 2, 8); hit(0, 1, 0, 3, 8);
    dis(0, 0, 0, 0, 1, 0, 8);
    // Group 6: CONFIRM_FRAMES=1 fires on one hit; a strobe in FIRE is ignored.
    hit(1, 1, 0, 1, 6);
    hit(1, 0, 0, 1, 6);
    idl(19, 1, 0, 0, 1, 6);
    miss(1, 0, 0, 1, 6);
    miss(1, 0, 0, 1, 6);
    miss(1, 0, 1, 0, 6);
    hit(1, 1, 0, 1, 6);
    idl(1, 1, 0, 0, 1, 6);

    // Reset state while reset_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trigger", 8'(trig0), 8'd0);
    chk("rst_armed", 8'(armed0), 8'd1);
    chk("rst_hit_count", 8'(hc0), 8'd0);
    chk("rst_c1_armed", 8'(armed1), 8'd1);
    reset_n = 1'b1;

    // Group 1: asynchronous reset in CONFIRM, then during a trigger pulse.
    step0(1, 1, 1);
    step0(1, 1, 1);
    chk("g1_pre_hit_count", 8'(hc0), 8'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("g1_async_hit_count", 8'(hc0), 8'd0);
    chk("g1_async_armed", 8'(armed0), 8'd1);
    #2 reset_n = 1'b1;
    step0(1, 1, 1);
    step0(1, 1, 1);
    step0(1, 1, 1);
    chk("g1_fire_trigger", 8'(trig0), 8'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("g1_trunc_trigger", 8'(trig0), 8'd0);
    chk("g1_trunc_armed", 8'(armed0), 8'd1);
    chk("g1_trunc_hit_count", 8'(hc0), 8'd0);
    #2 reset_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].dut == 1'b0) begin
        en0 = vecs[i].en; v0 = vecs[i].v; h0 = vecs[i].h;
        en1 = 1'b1;       v1 = 1'b0;      h1 = 1'b0;
      end else begin
        en1 = vecs[i].en; v1 = vecs[i].v; h1 = vecs[i].h;
        en0 = 1'b1;       v0 = 1'b0;      h0 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (vecs[i].dut == 1'b0) begin
        chk($sformatf("g%0d_v%0d_trigger", vecs[i].grp, i), 8'(trig0), 8'(vecs[i].trig));
        chk($sformatf("g%0d_v%0d_armed", vecs[i].grp, i), 8'(armed0), 8'(vecs[i].armed));
        chk($sformatf("g%0d_v%0d_hit_count", vecs[i].grp, i), 8'(hc0), 8'(vecs[i].hc));
      end else begin
        chk($sformatf("g%0d_v%0d_trigger", vecs[i].grp, i), 8'(trig1), 8'(vecs[i].trig));
        chk($sformatf("g%0d_v%0d_armed", vecs[i].grp, i), 8'(armed1), 8'(vecs[i].armed));
        chk($sformatf("g%0d_v%0d_hit_count", vecs[i].grp, i), 8'(hc1), 8'(vecs[i].hc));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alert_trigger.md
Name: alert_trigger

Overview:
- Upstream stage of the buzzer driver: converts per-frame detection results from the vision pipeline into a single-cycle `trigger` pulse.
- The buzzer consumes that pulse on its rising edge and beeps for a fixed 1 s.
- Adds temporal filtering (N consecutive hit frames), a post-fire cooldown, and a re-arm condition so a persistently present object does not retrigger endlessly.

Parameters:
- CONFIRM_FRAMES, 3: consecutive hit frames required to fire (legal range 1..15).
- RELEASE_FRAMES, 2: consecutive miss frames required after cooldown before re-arming (legal range 1..15).
- COOLDOWN_CYCLES, 100000000: clock cycles (2 s at 50 MHz) after firing during which detections are ignored (must be ≥1).

Ports:
- clk  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  level; 0 forces IDLE and suppresses trigger
- det_valid  input  1  one-cycle strobe, once per processed frame
- det_hit  input  1  detection result, qualified by det_valid
- trigger  output  1  one-cycle pulse; drives buzzer trigger
- armed  output  1  high in IDLE/CONFIRM (ready to fire)
- hit_count  output  4  current consecutive-hit count (status/LEDs)

Behaviour:
- Reset (async assert, sync deassert handled externally) values:
  - state=IDLE, trigger=0, armed=1, hit_count=0.
  - Cooldown counter=0, miss counter=0.
- A "frame event" is any cycle with det_valid=1. det_hit is ignored when det_valid=0.
- States:
  - IDLE: hit_count=0.
    - Frame event with hit → hit_count=1. If CONFIRM_FRAMES==1 go FIRE, else go CONFIRM.
    - Miss → stay.
  - CONFIRM:
    - Hit → hit_count+1. When the new count equals CONFIRM_FRAMES go FIRE.
    - Miss → hit_count=0, go IDLE.
  - FIRE: exactly one cycle.
    - trigger=1 (registered output, asserted in the cycle the state is FIRE).
    - Cooldown counter loaded 0; next state COOLDOWN.
    - A frame event arriving in the FIRE cycle is ignored.
  - COOLDOWN:
    - Counter increments each cycle; all frame events are ignored.
    - When counter == COOLDOWN_CYCLES-1 go REARM with miss counter=0.
  - REARM:
    - Miss → miss counter+1. Reaching RELEASE_FRAMES → IDLE with hit_count=0.
    - Hit → miss counter=0, stay (object still present).
- Output levels:
  - armed=1 only in IDLE and CONFIRM.
  - hit_count is held at CONFIRM_FRAMES through FIRE/COOLDOWN/REARM, then cleared on entry to IDLE.
- Latency:
  - The frame event completing confirmation is at cycle t. State=FIRE at t+1, so trigger=1 at t+1 and 0 at t+2.
  - Minimum spacing between two trigger pulses is 1 + COOLDOWN_CYCLES + (RELEASE_FRAMES + CONFIRM_FRAMES frame events).
- enable:
  - enable=0 has priority over all transitions: next state IDLE, counters cleared, trigger forced 0 that cycle.
  - Dropping enable mid-COOLDOWN aborts the cooldown.
- Widths:
  - Cooldown counter is $clog2(COOLDOWN_CYCLES+1) bits; no wrap is reachable.
  - hit/miss counters are 4 bits and saturate at their parameter value.
- Reset mid-operation: immediate return to reset values; a trigger pulse in flight is truncated.
- trigger is never high for more than one consecutive cycle. The buzzer edge-detects, so back-to-back pulses are forbidden by construction.

Decomposition:
- Package alert_pkg holds:
  - Enum state_t {IDLE, CONFIRM, FIRE, COOLDOWN, REARM}, 3-bit encoding.
  - localparam CNT_W=4.
  - Default timing constants CLK_HZ=50000000 and COOLDOWN_DEFAULT.
- One sub-module is natural: cooldown_timer.
  - Ports: load, busy, done pulse.
  - Parameterised by COOLDOWN_CYCLES; reusable by the buzzer duration counter later.
- FSM and frame counters stay in alert_trigger.

Test Plan:
Sim params: CONFIRM=3, RELEASE=2, COOLDOWN=20.
1. Reset with reset_n=0 mid-stream → trigger=0, armed=1, hit_count=0 immediately, asynchronous to clk.
2. Three det_valid strobes with hit=1 (gaps of 5 cycles) → trigger=1 for exactly one cycle, 1 cycle after the 3rd strobe; armed drops the same cycle.
3. Sequence hit, hit, miss, hit, hit → no trigger; hit_count goes 1,2,0,1,2.
4. Fire, then hits continue every 4 cycles → no second trigger during 20 cooldown cycles nor in REARM. After two consecutive misses, armed=1; three further hits → second trigger.
5. enable=0 asserted 10 cycles into cooldown, then re-enabled → state IDLE, armed=1; next 3 hits fire without waiting for the remaining cooldown.
6. CONFIRM_FRAMES=1 variant → single hit strobe yields trigger one cycle later; det_valid coincident with the FIRE cycle is ignored (no extra pulse).
